// File: rtl/ans_pkg.sv
// rtl/ans_pkg.sv - shared symbol width, core command codes and sequencer states
package ans_pkg;

  localparam int SYM_WIDTH = 4;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_ENC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  // Load is always allowed; enc/dec need a frequency table in place.
  function automatic logic mode_legal(input logic [1:0] mode, input logic table_ok);
    return (mode == CMD_LOAD) || ((mode != CMD_IDLE) && table_ok);
  endfunction

endpackage

// File: rtl/ans_sequencer_if.sv
// rtl/ans_sequencer_if.sv - host, core and status signals of the ANS job sequencer
interface ans_sequencer_if
  import ans_pkg::*;
#(
  parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
  parameter int LEN_WIDTH = 8
);
  logic                 job_vld;
  logic                 job_rdy;
  logic [1:0]           job_mode;
  logic [LEN_WIDTH-1:0] job_len;
  logic [SYM_WIDTH-1:0] s_data;
  logic                 s_vld;
  logic                 s_rdy;
  logic [SYM_WIDTH-1:0] m_data;
  logic                 m_vld;
  logic                 m_rdy;
  logic [1:0]           core_cmd;
  logic [SYM_WIDTH-1:0] core_in;
  logic                 core_in_vld;
  logic                 core_in_rdy;
  logic [SYM_WIDTH-1:0] core_out;
  logic                 core_out_vld;
  logic                 core_out_rdy;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 table_loaded;
  logic [15:0]          perf_cycles;
  logic [LEN_WIDTH-1:0] perf_out_syms;

  modport slave (
    input  job_vld, job_mode, job_len, s_data, s_vld, m_rdy,
           core_in_rdy, core_out, core_out_vld,
    output job_rdy, s_rdy, m_data, m_vld, core_cmd, core_in, core_in_vld,
           core_out_rdy, busy, done, err, table_loaded, perf_cycles, perf_out_syms
  );

  modport master (
    output job_vld, job_mode, job_len, s_data, s_vld, m_rdy,
           core_in_rdy, core_out, core_out_vld,
    input  job_rdy, s_rdy, m_data, m_vld, core_cmd, core_in, core_in_vld,
           core_out_rdy, busy, done, err, table_loaded, perf_cycles, perf_out_syms
  );

endinterface

// File: rtl/ans_seq_drain_timer.sv
// rtl/ans_seq_drain_timer.sv - counts consecutive core-idle cycles during drain
module ans_seq_drain_timer #(
  parameter int DRAIN_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int TW = $clog2(DRAIN_CYCLES + 1);

  logic [TW-1:0] r_count;

  // Fires on the DRAIN_CYCLES-th consecutive idle cycle so the FSM leaves on that edge.
  assign o_expired = i_enable && (r_count == TW'(DRAIN_CYCLES - 1));

  // Idle-cycle counter; any core output or leaving drain restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ans_sequencer.sv
// rtl/ans_sequencer.sv - ANS job sequencer top; ANS_SEQ_PERF_EN adds perf counters
module ans_sequencer
  import ans_pkg::*;
#(
  parameter int SYM_WIDTH    = ans_pkg::SYM_WIDTH,
  parameter int LEN_WIDTH    = 8,
  parameter int LOAD_LEN     = 16,
  parameter int DRAIN_CYCLES = 15
) (
  input logic           clk,
  input logic           rst,
  ans_sequencer_if.slave bus
);
  seq_state_e           r_state;
  logic [1:0]           r_mode;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_err;
  logic                 r_table_loaded;

  logic w_idle, w_stream, w_drain, w_fwd_out, w_legal;
  logic w_accept, w_reject, w_full, w_in_hs, w_last;
  logic w_drain_clr, w_drain_en, w_expired, w_m_vld;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_stream  = (r_state == ST_STREAM);
  assign w_drain   = (r_state == ST_DRAIN);
  assign w_fwd_out = w_stream || w_drain;
  assign w_legal   = mode_legal(bus.job_mode, r_table_loaded);
  assign w_accept  = bus.job_vld && w_idle && w_legal;
  assign w_reject  = bus.job_vld && w_idle && !w_legal;
  assign w_full    = (r_cnt == r_len);
  assign w_in_hs   = w_stream && bus.s_vld && bus.core_in_rdy && !w_full;
  assign w_last    = w_in_hs && ((r_cnt + 1'b1) == r_len);

  // Job FSM: latch the descriptor, feed the core, drain it, then report completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= CMD_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_mode  <= bus.job_mode;
            r_len   <= (bus.job_mode == CMD_LOAD) ? LEN_WIDTH'(LOAD_LEN) : bus.job_len;
            r_cnt   <= '0;
          end
        end
        ST_SETUP:  r_state <= (r_len == '0) ? ST_DONE : ST_STREAM;
        ST_STREAM: begin
          if (w_in_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= (r_mode == CMD_LOAD) ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: if (w_expired) r_state <= ST_DONE;
        ST_DONE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reject pulse one cycle after the refused descriptor; table flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err          <= 1'b0;
      r_table_loaded <= 1'b0;
    end else begin
      r_err <= w_reject;
      if ((r_state == ST_DONE) && (r_mode == CMD_LOAD)) r_table_loaded <= 1'b1;
    end
  end

  assign w_drain_clr = !w_drain || bus.core_out_vld;
  assign w_drain_en  = w_drain && !bus.core_out_vld;

  ans_seq_drain_timer #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_drain_clr),
    .i_enable (w_drain_en),
    .o_expired(w_expired)
  );

  // Data paths are plain pass-through; everything is masked outside its active states.
  assign w_m_vld          = w_fwd_out && bus.core_out_vld;
  assign bus.job_rdy      = w_idle;
  assign bus.busy         = !w_idle;
  assign bus.done         = (r_state == ST_DONE);
  assign bus.err          = r_err;
  assign bus.table_loaded = r_table_loaded;
  assign bus.core_cmd     = w_idle ? CMD_IDLE : r_mode;
  assign bus.core_in      = w_stream ? bus.s_data : {SYM_WIDTH{1'b0}};
  assign bus.core_in_vld  = w_stream && bus.s_vld && !w_full;
  assign bus.s_rdy        = w_stream && bus.core_in_rdy && !w_full;
  assign bus.m_data       = w_fwd_out ? bus.core_out : {SYM_WIDTH{1'b0}};
  assign bus.m_vld        = w_m_vld;
  assign bus.core_out_rdy = w_fwd_out && bus.m_rdy;

`ifdef ANS_SEQ_PERF_EN
  logic [15:0]          r_perf_cycles;
  logic [LEN_WIDTH-1:0] r_perf_out_syms;

  // Per-job statistics, restarted on accept and frozen while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles   <= '0;
      r_perf_out_syms <= '0;
    end else if (w_accept) begin
      r_perf_cycles   <= '0;
      r_perf_out_syms <= '0;
    end else begin
      if (!w_idle && (r_perf_cycles != 16'hFFFF)) r_perf_cycles <= r_perf_cycles + 1'b1;
      if (w_m_vld && bus.m_rdy) r_perf_out_syms <= r_perf_out_syms + 1'b1;
    end
  end

  assign bus.perf_cycles   = r_perf_cycles;
  assign bus.perf_out_syms = r_perf_out_syms;
`else
  assign bus.perf_cycles   = '0;
  assign bus.perf_out_syms = '0;
`endif

endmodule
